// File: rtl/seq_monitor_pkg.sv
// Shared types and helpers for the seq_monitor sequence checker.
// Optional coverage outputs in seq_monitor are enabled by SEQMON_COVER_EN.
package seq_monitor_pkg;

  typedef enum logic [1:0] {IDLE, JRUN, WAITK} thr_state_e;

  // J-run counter width.
  function automatic int jcnt_w(input int num_j);
    return (num_j < 1) ? 1 : $clog2(num_j + 1);
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max_v);
    logic [63:0] s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/seq_thread.sv
// One consequent checker: J[*NUM_J] ##1 K, started by alloc, killed by X.
//   state | meaning
//   IDLE  | free, may be allocated
//   JRUN  | counting consecutive J cycles (j_left = J cycles still needed - 1)
//   WAITK | NUM_J J cycles seen, K required in the next sampled cycle
module seq_thread
  import seq_monitor_pkg::*;
#(
  parameter int NUM_J = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic alloc,
  input  logic J,
  input  logic K,
  input  logic X,
  output logic pass,
  output logic fail,
  output logic busy
);

  localparam int JW = jcnt_w(NUM_J);
  localparam logic [JW-1:0] J_LOAD = JW'(NUM_J - 1);

  thr_state_e state, state_nxt;
  logic [JW-1:0] j_left, j_left_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      j_left <= '0;
    end else begin
      state  <= state_nxt;
      j_left <= j_left_nxt;
    end
  end

  // Allocation wins over a resolution in the same cycle: the slot is reused.
  always_comb begin
    state_nxt  = state;
    j_left_nxt = j_left;
    if (X) begin
      state_nxt = IDLE;
    end else if (alloc) begin
      state_nxt  = JRUN;
      j_left_nxt = J_LOAD;
    end else begin
      case (state)
        JRUN: begin
          if (!J)                  state_nxt  = IDLE;
          else if (j_left == '0)   state_nxt  = WAITK;
          else                     j_left_nxt = j_left - JW'(1);
        end
        WAITK:   state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    pass = !X && (state == WAITK) && K;
    fail = !X && (((state == JRUN) && !J) || ((state == WAITK) && !K));
  end

endmodule

// File: rtl/seq_monitor.sv
// Checks C ##1 B[*1:MAX_B] ##1 A |=> J[*NUM_J] ##1 K, disabled by X, with NTHREADS
// overlapping attempts. Define SEQMON_COVER_EN to add ant_cnt and blen_hist.
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int MAX_B    = 3,
  parameter int NUM_J    = 4,
  parameter int NTHREADS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      A,
  input  logic                      B,
  input  logic                      C,
  input  logic                      J,
  input  logic                      K,
  input  logic                      X,
  output logic                      pass,
  output logic                      fail,
  output logic                      abort,
  output logic                      overflow,
  output logic [CNT_W-1:0]          pass_cnt,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic [CNT_W-1:0]          abort_cnt,
`ifdef SEQMON_COVER_EN
  output logic [NTHREADS-1:0]       busy,
  output logic [CNT_W-1:0]          ant_cnt,
  output logic [MAX_B*CNT_W-1:0]    blen_hist
`else
  output logic [NTHREADS-1:0]       busy
`endif
);

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic                cprev;
  logic [MAX_B:1]      bv;
  logic                match;
  logic                active;
  logic                taken;
  logic [NTHREADS-1:0] thr_pass, thr_fail, thr_free, alloc_vec;
  logic [63:0]         n_pass, n_fail;

  assign match    = A & (|bv) & ~X;
  assign active   = cprev | (|bv) | (|busy);
  assign thr_free = ~busy | thr_pass | thr_fail;
  assign n_pass   = 64'($countones(thr_pass));
  assign n_fail   = 64'($countones(thr_fail));

  always_comb begin
    alloc_vec = '0;
    taken     = 1'b0;
    for (int i = 0; i < NTHREADS; i++) begin
      if (!taken && thr_free[i]) begin
        alloc_vec[i] = match;
        taken        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NTHREADS; g++) begin : g_thr
    seq_thread #(.NUM_J(NUM_J)) u_thr (
      .CLK   (CLK),
      .RST_N (RST_N),
      .alloc (alloc_vec[g]),
      .J     (J),
      .K     (K),
      .X     (X),
      .pass  (thr_pass[g]),
      .fail  (thr_fail[g]),
      .busy  (busy[g])
    );
  end

  // bv[k]: C was seen k+1 cycles ago followed by k consecutive B cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cprev     <= 1'b0;
      bv        <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      abort     <= 1'b0;
      overflow  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      pass     <= |thr_pass;
      fail     <= |thr_fail;
      pass_cnt <= CNT_W'(sat_add(64'(pass_cnt), n_pass, CNT_MAX));
      fail_cnt <= CNT_W'(sat_add(64'(fail_cnt), n_fail, CNT_MAX));
      if (X) begin
        cprev <= 1'b0;
        bv    <= '0;
        abort <= active;
        if (active) abort_cnt <= CNT_W'(sat_add(64'(abort_cnt), 64'd1, CNT_MAX));
      end else begin
        cprev <= C;
        bv[1] <= cprev & B;
        for (int k = 2; k <= MAX_B; k++) bv[k] <= bv[k-1] & B;
        abort <= 1'b0;
        if (match && !taken) overflow <= 1'b1;
      end
    end
  end

`ifdef SEQMON_COVER_EN
  logic [CNT_W-1:0] hist [1:MAX_B];
  int               shortest;

  always_comb begin
    shortest = 0;
    for (int k = MAX_B; k >= 1; k--) if (bv[k]) shortest = k;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ant_cnt <= '0;
      for (int k = 1; k <= MAX_B; k++) hist[k] <= '0;
    end else if (match) begin
      ant_cnt <= CNT_W'(sat_add(64'(ant_cnt), 64'd1, CNT_MAX));
      for (int k = 1; k <= MAX_B; k++)
        if (shortest == k) hist[k] <= CNT_W'(sat_add(64'(hist[k]), 64'd1, CNT_MAX));
    end
  end

  for (genvar h = 1; h <= MAX_B; h++) begin : g_hist
    assign blen_hist[(h-1)*CNT_W +: CNT_W] = hist[h];
  end
`else
`endif

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: MAX_B=3 main instance plus a MAX_B=4 twin on the same inputs.
module tb_seq_monitor;

  localparam int CW = 16;

  logic CLK, RST_N;
  logic A, B, C, J, K, X;

  logic          pass, fail, abort, overflow;
  logic [CW-1:0] pass_cnt, fail_cnt, abort_cnt;
  logic [1:0]    busy;

  logic          pass_4, fail_4, abort_4, overflow_4;
  logic [CW-1:0] pass_cnt_4, fail_cnt_4, abort_cnt_4;
  logic [1:0]    busy_4;

`ifdef SEQMON_COVER_EN
  logic [CW-1:0]   ant_cnt, ant_cnt_4;
  logic [3*CW-1:0] blen_hist;
  logic [4*CW-1:0] blen_hist_4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  seq_monitor #(.MAX_B(3), .NUM_J(4), .NTHREADS(2), .CNT_W(CW)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .C(C), .J(J), .K(K), .X(X),
    .pass(pass), .fail(fail), .abort(abort), .overflow(overflow),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .abort_cnt(abort_cnt),
`ifdef SEQMON_COVER_EN
    .ant_cnt(ant_cnt), .blen_hist(blen_hist),
`endif
    .busy(busy)
  );

  seq_monitor #(.MAX_B(4), .NUM_J(4), .NTHREADS(2), .CNT_W(CW)) u_dut_b4 (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .C(C), .J(J), .K(K), .X(X),
    .pass(pass_4), .fail(fail_4), .abort(abort_4), .overflow(overflow_4),
    .pass_cnt(pass_cnt_4), .fail_cnt(fail_cnt_4), .abort_cnt(abort_cnt_4),
`ifdef SEQMON_COVER_EN
    .ant_cnt(ant_cnt_4), .blen_hist(blen_hist_4),
`endif
    .busy(busy_4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one sampled cycle; returns 1 time unit after the sampling edge.
  task automatic cyc(input logic c, input logic b, input logic a,
                     input logic j, input logic k, input logic x);
    C = c; B = b; A = a; J = j; K = k; X = x;
    @(posedge CLK);
    #1;
    C = 0; B = 0; A = 0; J = 0; K = 0; X = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    {A, B, C, J, K, X} = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_abort", abort, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnts", {pass_cnt, fail_cnt, abort_cnt}, 0);
    RST_N = 1'b1;

    // C;B;B;B with no A: nothing allocated
    cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,1,0,0,0,0);
    cyc(0,0,0,0,0,0);
    chk("noa_busy", busy, 0);
    chk("noa_cnts", {pass_cnt, fail_cnt, abort_cnt}, 0);

    // C;B;A;J;J;J;J;K -> pass
    do_reset();
    cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0);
    chk("p_busy_alloc", busy, 2'b01);
    cyc(0,0,0,1,0,0); cyc(0,0,0,1,0,0); cyc(0,0,0,1,0,0); cyc(0,0,0,1,0,0);
    chk("p_busy_waitk", busy, 2'b01);
    chk("p_nopass_early", pass, 0);
    cyc(0,0,0,0,1,0);
    chk("p_pass", pass, 1);
    chk("p_pass_cnt", pass_cnt, 1);
    chk("p_fail_cnt", fail_cnt, 0);
    chk("p_busy_done", busy, 0);
    cyc(0,0,0,0,0,0);
    chk("p_pass_pulse", pass, 0);

    // B run of 4: no match at MAX_B=3, match at MAX_B=4
    do_reset();
    cyc(1,0,0,0,0,0);
    repeat (4) cyc(0,1,0,0,0,0);
    cyc(0,0,1,0,0,0);
    chk("b4_busy", busy, 0);
    chk("b4_busy_mb4", busy_4, 2'b01);
    repeat (4) cyc(0,0,0,1,0,0);
    cyc(0,0,0,0,1,0);
    chk("b4_pass_cnt", pass_cnt, 0);
    chk("b4_pass_cnt_mb4", pass_cnt_4, 1);

    // Missing K after the J run -> fail; the late K is ignored
    do_reset();
    cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0);
    repeat (4) cyc(0,0,0,1,0,0);
    cyc(0,0,0,0,0,0);
    chk("f_fail", fail, 1);
    chk("f_fail_cnt", fail_cnt, 1);
    chk("f_busy", busy, 0);
    cyc(0,0,0,0,1,0);
    chk("f_late_k_pass", pass, 0);
    chk("f_late_k_cnts", {pass_cnt, fail_cnt}, {16'd0, 16'd1});

    // X mid J-run -> abort
    do_reset();
    cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0);
    cyc(0,0,0,1,0,0); cyc(0,0,0,1,0,0);
    chk("x_busy_before", busy, 2'b01);
    cyc(0,0,0,0,0,1);
    chk("x_abort", abort, 1);
    chk("x_abort_cnt", abort_cnt, 1);
    chk("x_busy", busy, 0);
    chk("x_passfail", {pass, fail}, 0);
    cyc(0,0,0,0,0,0);
    chk("x_abort_pulse", abort, 0);
    cyc(0,0,0,0,0,1);
    chk("x_idle_noabort", abort, 0);
    chk("x_idle_cnt", abort_cnt, 1);

    // Asynchronous reset while a thread is in JRUN
    cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0); cyc(0,0,1,0,0,0);
    cyc(0,0,0,1,0,0); cyc(0,0,0,1,0,0);
    chk("ar_busy_before", busy, 2'b01);
    RST_N = 1'b0;
    #2;
    chk("ar_busy", busy, 0);
    chk("ar_abort_cnt", abort_cnt, 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Three overlapping attempts with two threads -> overflow, two passes
    cyc(1,0,0,0,0,0);
    cyc(1,1,0,0,0,0);
    cyc(0,1,1,0,0,0);
    chk("o_busy1", busy, 2'b01);
    cyc(1,0,1,1,0,0);
    chk("o_busy2", busy, 2'b11);
    chk("o_noovf", overflow, 0);
    cyc(0,1,0,1,0,0);
    cyc(0,0,1,1,0,0);
    chk("o_ovf", overflow, 1);
    chk("o_busy3", busy, 2'b11);
    cyc(0,0,0,1,0,0);
    cyc(0,0,0,1,1,0);
    chk("o_pass1", pass, 1);
    chk("o_pass_cnt1", pass_cnt, 1);
    chk("o_busy4", busy, 2'b10);
    cyc(0,0,0,0,1,0);
    chk("o_pass2", pass, 1);
    chk("o_pass_cnt2", pass_cnt, 2);
    chk("o_fail_cnt", fail_cnt, 0);
    chk("o_busy_end", busy, 0);
    chk("o_ovf_sticky", overflow, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_monitor.md
Name: seq_monitor

Overview:
- Synthesizable, parametrised hardware sequence checker.
- Property checked: C ##1 B[*1:MAX_B] ##1 A |=> J[*NUM_J] ##1 K, disabled by X.
- Generalises the team's fixed-length SVA sequence checks:
  - configurable B-run and J-run lengths;
  - NTHREADS concurrent overlapping attempts;
  - pass/fail/abort counters and thread-overflow detection.
- Instantiated alongside the DUT in testbenches, or left in silicon as an on-chip protocol monitor.

Parameters:
- MAX_B, 3, maximum consecutive B cycles accepted in the enabling sequence (>=1).
- NUM_J, 4, exact consecutive J cycles required before K (>=1).
- NTHREADS, 2, concurrent consequent checkers (>=1).
- CNT_W, 16, width of the saturating event counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- A, B, C, J, K  in  1 each  monitored signals, synchronous to CLK.
- X  in  1  disable/abort; kills all attempts in progress.
- pass  out  1  one-cycle pulse: at least one thread passed.
- fail  out  1  one-cycle pulse: at least one thread failed.
- abort  out  1  one-cycle pulse: X sampled while any tracker or thread was active.
- overflow  out  1  sticky: an antecedent match found no free thread. Cleared only by reset.
- pass_cnt, fail_cnt, abort_cnt  out  CNT_W each  saturating event counts.
- busy  out  NTHREADS  per-thread active flags.

Behaviour:
- Reset: every output 0; all trackers and threads idle. Reset is asynchronous and honoured mid-sequence.
- Sampling: inputs are sampled on each rising edge, called cycle n. Outputs are registered, so an event decided in cycle n appears in cycle n+1.
- Antecedent tracker (bit vector bv[1..MAX_B], not an FSM):
  - cprev <= C.
  - bv[1] <= cprev & B.
  - bv[k] <= bv[k-1] & B.
  - Match in cycle n when A & |bv.
  - Overlapping enabling sequences are tracked simultaneously.
  - A B run longer than MAX_B drops out of bv; no match.
  - A B and C together count for both roles.
- Thread allocation:
  - A match allocates the lowest-index idle thread, which starts checking at cycle n+1.
  - No idle thread: overflow <= 1, match discarded, no fail.
  - A thread freed in cycle n may be reallocated in the same cycle n.
- Thread FSM states and transitions:
  - IDLE -> JRUN(cnt=0) on allocation.
  - JRUN: J sampled -> cnt+1; when cnt reaches NUM_J, go to WAITK. J not sampled -> fail, go to IDLE.
  - WAITK: K -> pass, go to IDLE. No K -> fail, go to IDLE.
  - J and K together in WAITK: pass.
- Multiple threads resolving in one cycle:
  - pass/fail pulses are ORed.
  - Counters add the popcount of resolving threads, saturating at 2^CNT_W-1.
- X sampled in cycle n:
  - All threads go to IDLE; bv and cprev clear.
  - No pass/fail is produced that cycle; any match in that cycle is dropped.
  - abort pulses and abort_cnt increments by 1 if anything was active.
- X has priority over matches and resolutions in the same cycle.

Optional Feature:
- Macro: SEQMON_COVER_EN.
- Defined:
  - Adds output ant_cnt (CNT_W): saturating count of antecedent matches.
  - Adds output blen_hist (MAX_B*CNT_W): per-B-run-length match histogram.
  - The length recorded is the shortest matching length when several bv bits are set.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- seq_monitor_pkg holds:
  - typedef enum thr_state_e {IDLE, JRUN, WAITK};
  - a saturating-add function;
  - localparam helpers for counter widths ($clog2(NUM_J+1)).
- One sub-module, seq_thread: a single consequent checker FSM with alloc, J, K, X inputs and pass, fail, busy outputs.
- seq_monitor instantiates NTHREADS copies via generate.

Test Plan:
- Parameter set for all scenarios: MAX_B=3, NUM_J=4, NTHREADS=2.
- "C;B;B;B" (no A) -> no thread allocated; busy stays 0; all counts 0.
- "C;B;A;J;J;J;J;K" -> thread 0 busy from the cycle after the A sample; pass pulse one cycle after the K sample; pass_cnt=1, fail_cnt=0.
- "C;B;B;B;B;A;J;J;J;J;K" (B run 4 > MAX_B) -> no match; counts unchanged. With MAX_B=4 the same stimulus gives pass_cnt=1.
- "C;B;A;J;J;J;J;;K" -> fail pulse one cycle after the empty cycle; fail_cnt=1; the late K has no effect.
- "C;B;B;A;J;J;X" -> abort pulse; abort_cnt=1; busy returns to 0; no pass/fail. Also drive RST_N low mid-JRUN -> outputs 0 immediately (asynchronous).
- Three back-to-back enabling sequences "C;BC;AB;CA..." with NTHREADS=2 -> first two attempts occupy busy=2'b11; third match sets overflow=1; two passes in later cycles give pass_cnt=2.
